// File: rtl/matmul_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_host_ctrl
//  Description : Host-side sequencer for the matrix-multiply accelerator.
//                Streams matrix X then matrix Y from a valid/ready input into
//                the accelerator's X/Y BRAM write ports, pulses start, waits
//                for a rising edge on done, then reads the Z BRAM back out as
//                a valid/ready output stream.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock                  : single rising-edge clock
//    reset                  : synchronous, active-low
//    in_data/in_valid/in_ready    : input word stream (X words, then Y words)
//    out_data/out_valid/out_ready : Z result word stream
//    job_done               : one-cycle pulse after the final Z handshake
//    busy                   : high from first X handshake until job_done
//    x_din/x_wr_addr/x_wr_en: X BRAM write port
//    y_din/y_wr_addr/y_wr_en: Y BRAM write port
//    start                  : one-cycle accelerator start pulse
//    done                   : accelerator completion flag (edge-detected)
//    z_rd_addr              : Z BRAM read address
//    z_dout                 : Z BRAM read data, one cycle after the address
// ============================================================================
module matmul_host_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int MATRIX_SIZE = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  job_done,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  y_wr_en,
    output logic                  start,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout
);

    typedef enum logic [2:0] {
        S_LOAD_X  = 3'd0,
        S_LOAD_Y  = 3'd1,
        S_KICK    = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(MATRIX_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_one      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_zero     = '0;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_done_prev;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_job_done;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_x_din;
    logic [ADDR_WIDTH-1:0] r_x_wr_addr;
    logic                  r_x_wr_en;
    logic [DATA_WIDTH-1:0] r_y_din;
    logic [ADDR_WIDTH-1:0] r_y_wr_addr;
    logic                  r_y_wr_en;
    logic                  r_start;
    logic [ADDR_WIDTH-1:0] r_z_rd_addr;

    logic w_in_hs;
    logic w_out_hs;
    logic w_done_rise;
    logic w_last;

    assign w_in_hs     = in_valid & r_in_ready;
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_done_rise = done & ~r_done_prev;
    assign w_last      = (r_cnt == c_last_idx);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_LOAD_X;
            r_cnt       <= c_zero;
            r_done_prev <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_job_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_x_din     <= '0;
            r_x_wr_addr <= c_zero;
            r_x_wr_en   <= 1'b0;
            r_y_din     <= '0;
            r_y_wr_addr <= c_zero;
            r_y_wr_en   <= 1'b0;
            r_start     <= 1'b0;
            r_z_rd_addr <= c_zero;
        end else begin
            // Single-cycle strobes default low every cycle.
            r_x_wr_en  <= 1'b0;
            r_y_wr_en  <= 1'b0;
            r_start    <= 1'b0;
            r_job_done <= 1'b0;

            case (r_state)
                S_LOAD_X: begin
                    // Re-asserted here so ready comes up one cycle after reset release.
                    r_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        r_x_wr_en   <= 1'b1;
                        r_x_wr_addr <= r_cnt;
                        r_x_din     <= in_data;
                        r_busy      <= 1'b1;
                        if (w_last) begin
                            r_cnt   <= c_zero;
                            r_state <= S_LOAD_Y;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end

                S_LOAD_Y: begin
                    if (w_in_hs) begin
                        r_y_wr_en   <= 1'b1;
                        r_y_wr_addr <= r_cnt;
                        r_y_din     <= in_data;
                        if (w_last) begin
                            r_cnt      <= c_zero;
                            r_in_ready <= 1'b0;
                            r_state    <= S_KICK;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end

                S_KICK: begin
                    // The final Y write is in flight this cycle; start follows it
                    // so the accelerator never sees start alongside a write.
                    r_start     <= 1'b1;
                    // Seed the previous sample high: a done level still asserted
                    // from an earlier job must fall and rise again to count.
                    r_done_prev <= 1'b1;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    r_done_prev <= done;
                    if (w_done_rise) begin
                        r_cnt       <= c_zero;
                        r_z_rd_addr <= c_zero;
                        r_state     <= S_RD_ADDR;
                    end
                end

                S_RD_ADDR: begin
                    // Address is already registered; this cycle lets the BRAM read.
                    r_state <= S_RD_DATA;
                end

                S_RD_DATA: begin
                    r_out_data  <= z_dout;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end

                S_OUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_job_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cnt      <= c_zero;
                            r_in_ready <= 1'b1;
                            r_state    <= S_LOAD_X;
                        end else begin
                            r_cnt       <= r_cnt + c_one;
                            r_z_rd_addr <= r_cnt + c_one;
                            r_state     <= S_RD_ADDR;
                        end
                    end
                end

                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= S_LOAD_X;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign job_done  = r_job_done;
    assign busy      = r_busy;
    assign x_din     = r_x_din;
    assign x_wr_addr = r_x_wr_addr;
    assign x_wr_en   = r_x_wr_en;
    assign y_din     = r_y_din;
    assign y_wr_addr = r_y_wr_addr;
    assign y_wr_en   = r_y_wr_en;
    assign start     = r_start;
    assign z_rd_addr = r_z_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_matmul_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_host_ctrl
//  Description : Self-checking bench for matmul_host_ctrl (MATRIX_SIZE=4,
//                ADDR_WIDTH=3). Random input words and Z contents are checked
//                against a word-index reference: word i of a job goes to X
//                (i < 4) or Y at address i mod 4, and Z words come back in
//                address order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_host_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int MS = 4;

    logic          clock;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          job_done;
    logic          busy;
    logic [DW-1:0] x_din;
    logic [AW-1:0] x_wr_addr;
    logic          x_wr_en;
    logic [DW-1:0] y_din;
    logic [AW-1:0] y_wr_addr;
    logic          y_wr_en;
    logic          start;
    logic          done;
    logic [AW-1:0] z_rd_addr;
    logic [DW-1:0] z_dout;

    matmul_host_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MATRIX_SIZE(MS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .job_done (job_done),
        .busy     (busy),
        .x_din    (x_din),
        .x_wr_addr(x_wr_addr),
        .x_wr_en  (x_wr_en),
        .y_din    (y_din),
        .y_wr_addr(y_wr_addr),
        .y_wr_en  (y_wr_en),
        .start    (start),
        .done     (done),
        .z_rd_addr(z_rd_addr),
        .z_dout   (z_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Z BRAM model: registered read, data one cycle after the address.
    logic [DW-1:0] zmem [8];
    always @(posedge clock) z_dout <= zmem[z_rd_addr];

    int            n_asserts = 0;
    int            n_fail    = 0;
    logic [DW-1:0] in_words [2*MS];
    int            stall_len [MS];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Feed the first n words of in_words; with n == 2*MS also check the start pulse.
    task automatic load_job(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            if (bubbles && i != 0) begin
                int nb;
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    tick();
                    chk("idle_x_wr_en", x_wr_en, 0);
                    chk("idle_y_wr_en", y_wr_en, 0);
                end
            end
            in_valid = 1'b1;
            in_data  = in_words[i];
            chk("load_in_ready", in_ready, 1);
            tick();
            if (i < MS) begin
                chk("x_wr_en", x_wr_en, 1);
                chk("y_wr_en_quiet", y_wr_en, 0);
                chk("x_wr_addr", x_wr_addr, DW'(i % MS));
                chk("x_din", x_din, in_words[i]);
            end else begin
                chk("y_wr_en", y_wr_en, 1);
                chk("x_wr_en_quiet", x_wr_en, 0);
                chk("y_wr_addr", y_wr_addr, DW'(i % MS));
                chk("y_din", y_din, in_words[i]);
            end
            chk("load_start_low", start, 0);
            chk("load_busy", busy, 1);
        end
        if (n == 2*MS) begin
            // Extra input during KICK/WAIT must be ignored.
            in_valid = 1'b1;
            in_data  = $urandom;
            chk("kick_in_ready", in_ready, 0);
            tick();
            chk("start_pulse", start, 1);
            chk("start_x_wr_en", x_wr_en, 0);
            chk("start_y_wr_en", y_wr_en, 0);
            tick();
            chk("start_single", start, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_wait(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
            chk("wait_out_valid", out_valid, 0);
            chk("wait_x_wr_en", x_wr_en, 0);
            chk("wait_y_wr_en", y_wr_en, 0);
            chk("wait_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
    endtask

    // Entered in the cycle after the done rise (first RD_ADDR); out_ready is 1.
    task automatic read_job();
        logic [DW-1:0] exp_q [$];
        for (int k = 0; k < MS; k++) exp_q.push_back(zmem[k]);
        for (int k = 0; k < MS; k++) begin
            logic [DW-1:0] exp_word;
            exp_word = exp_q.pop_front();
            chk("rd_addr", z_rd_addr, DW'(k));
            chk("rd_addr_valid", out_valid, 0);
            chk("rd_busy", busy, 1);
            chk("rd_job_done", job_done, 0);
            tick();
            chk("rd_data_valid", out_valid, 0);
            tick();
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, exp_word);
            for (int s = 0; s < stall_len[k]; s++) begin
                out_ready = 1'b0;
                tick();
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, exp_word);
                chk("stall_addr", z_rd_addr, DW'(k));
            end
            out_ready = 1'b1;
            tick();
        end
        chk("job_done_pulse", job_done, 1);
        chk("busy_fall", busy, 0);
        chk("end_out_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
        tick();
        chk("job_done_single", job_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 8; k++) zmem[k] = '0;

        // ---- Reset ------------------------------------------------------
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x_wr_en", x_wr_en, 0);
        chk("rst_y_wr_en", y_wr_en, 0);
        chk("rst_x_wr_addr", x_wr_addr, 0);
        chk("rst_x_din", x_din, 0);
        chk("rst_y_din", y_din, 0);
        chk("rst_start", start, 0);
        chk("rst_z_rd_addr", z_rd_addr, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // ---- Job 1: no bubbles, done high at WAIT entry, stall on word 2 --
        for (int k = 0; k < MS; k++) zmem[k] = 32'hA0 + DW'(k);
        for (int i = 0; i < 2*MS; i++) in_words[i] = $urandom;
        for (int k = 0; k < MS; k++) stall_len[k] = (k == 2) ? 5 : 0;
        out_ready = 1'b1;
        done      = 1'b1;
        load_job(2*MS, 1'b0);
        idle_wait(5);
        done = 1'b0;
        idle_wait(10);
        done = 1'b1;
        tick();
        read_job();

        // ---- Job 2: reset after the 6th input word ----------------------
        done = 1'b0;
        for (int i = 0; i < 2*MS; i++) in_words[i] = $urandom;
        load_job(6, 1'b0);
        reset = 1'b0;
        tick();
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_x_wr_en", x_wr_en, 0);
        chk("mid_rst_y_wr_en", y_wr_en, 0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_job_done", job_done, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_release_ready", in_ready, 1);

        // ---- Job 3: random bubbles, random stalls, random Z -------------
        for (int k = 0; k < MS; k++) zmem[k] = $urandom;
        for (int i = 0; i < 2*MS; i++) in_words[i] = $urandom;
        for (int k = 0; k < MS; k++) stall_len[k] = $urandom_range(0, 3);
        load_job(2*MS, 1'b1);
        idle_wait($urandom_range(1, 6));
        done = 1'b1;
        tick();
        done = 1'b0;
        read_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
